// File: rtl/npu_sram_pkg.sv
// npu_sram_pkg: shared sram_B geometry, port id and command types
package npu_sram_pkg;
  localparam int SRAM_B_ADDR_W = 10;
  localparam int SRAM_B_DATA_W = 8;
  localparam int SRAM_B_RD_LAT = 1;
  typedef logic port_id_t;
  typedef struct packed {
    logic we;
    logic [SRAM_B_ADDR_W-1:0] addr;
    logic [SRAM_B_DATA_W-1:0] din;
  } sram_cmd_t;
endpackage

// File: rtl/sram_b_arbiter_if.sv
// sram_b_arbiter_if: two request/response ports plus sram_B pins; master = requesters and memory, slave = arbiter
interface sram_b_arbiter_if
  import npu_sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_B_ADDR_W,
  parameter int DATA_W = SRAM_B_DATA_W
);
  logic p0_valid, p0_ready, p0_we, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic p1_valid, p1_ready, p1_we, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic sram_ce, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din, sram_dout;
  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata, p1_valid, p1_we, p1_addr, p1_wdata, sram_dout,
    input p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata, sram_ce, sram_we, sram_addr, sram_din
  );
  modport slave (
    input p0_valid, p0_we, p0_addr, p0_wdata, p1_valid, p1_we, p1_addr, p1_wdata, sram_dout,
    output p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata, sram_ce, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin grant; ports clk, rst_n, req[1:0] in, gnt[1:0] out (one-hot or zero)
module rr_arb2
  import npu_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  port_id_t prio;
  assign gnt = &req ? (prio ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (&req) prio <= ~prio;
endmodule

// File: rtl/sram_b_arbiter.sv
// sram_b_arbiter: round-robin sequencer owning sram_B; ports clk, rst_n, bus (slave: two valid/ready ports, read responses, sram pins)
module sram_b_arbiter
  import npu_sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_B_ADDR_W,
  parameter int DATA_W = SRAM_B_DATA_W,
  parameter int RD_LAT = SRAM_B_RD_LAT
) (
  input logic clk,
  input logic rst_n,
  sram_b_arbiter_if.slave bus
);
  logic [1:0] gnt;
  logic acc, we_sel, rd;
  port_id_t sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] din_sel;
  logic [RD_LAT:0] pv, pp;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req({bus.p1_valid, bus.p0_valid}), .gnt(gnt));
  assign acc = |gnt;
  assign sel = gnt[1];
  assign we_sel = sel ? bus.p1_we : bus.p0_we;
  assign addr_sel = sel ? bus.p1_addr : bus.p0_addr;
  assign din_sel = sel ? bus.p1_wdata : bus.p0_wdata;
  assign rd = acc & ~we_sel;
  assign bus.p0_ready = gnt[0];
  assign bus.p1_ready = gnt[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.sram_ce <= 1'b0;
      bus.sram_we <= 1'b0;
      bus.sram_addr <= '0;
      bus.sram_din <= '0;
      pv <= '0;
      pp <= '0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
    end else begin
      bus.sram_ce <= acc;
      bus.sram_we <= acc & we_sel;
      if (acc) begin
        bus.sram_addr <= addr_sel;
        bus.sram_din <= din_sel;
      end
      pv <= {pv[RD_LAT-1:0], rd};
      pp <= {pp[RD_LAT-1:0], sel};
      bus.p0_rvalid <= pv[RD_LAT] & ~pp[RD_LAT];
      bus.p1_rvalid <= pv[RD_LAT] & pp[RD_LAT];
      if (pv[RD_LAT] & ~pp[RD_LAT]) bus.p0_rdata <= bus.sram_dout;
      if (pv[RD_LAT] & pp[RD_LAT]) bus.p1_rdata <= bus.sram_dout;
    end
endmodule

// File: tb/tb_sram_b_arbiter.sv
// tb_sram_b_arbiter: random and directed stimulus against a transaction-level model of the arbiter
module tb_sram_b_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rv0_cnt = 0;
  int rv1_cnt = 0;
  always #5 clk = ~clk;
  sram_b_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sram_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk)
    if (bus.sram_ce) begin
      if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
      else bus.sram_dout <= mem[bus.sram_addr];
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {logic p; logic [DW-1:0] d; int due;} rsp_t;
  rsp_t pend[$];
  logic [DW-1:0] ref_mem [1<<AW];
  logic mprio = 1'b0;
  logic e_ce = 1'b0, e_we = 1'b0, e_rv0, e_rv1;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din = '0, e_rd0 = '0, e_rd1 = '0;
  logic pw = 1'b0;
  logic [AW-1:0] pw_a, a;
  logic [DW-1:0] pw_d, d;
  logic w;
  logic [1:0] eg;
  always @(negedge clk) begin
    cyc++;
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    if (!rst_n) begin
      pend.delete();
      mprio = 1'b0;
      e_ce = 1'b0;
      e_we = 1'b0;
      e_addr = '0;
      e_din = '0;
      e_rd0 = '0;
      e_rd1 = '0;
      pw = 1'b0;
    end else begin
      if (pw) ref_mem[pw_a] = pw_d;
      pw = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].p) begin e_rv1 = 1'b1; e_rd1 = pend[0].d; end
        else begin e_rv0 = 1'b1; e_rd0 = pend[0].d; end
        void'(pend.pop_front());
      end
    end
    eg = (bus.p0_valid && bus.p1_valid) ? (mprio ? 2'b10 : 2'b01) : {bus.p1_valid, bus.p0_valid};
    chk("ready", {bus.p1_ready, bus.p0_ready}, eg);
    chk("p0_rvalid", bus.p0_rvalid, e_rv0);
    chk("p1_rvalid", bus.p1_rvalid, e_rv1);
    chk("p0_rdata", bus.p0_rdata, e_rd0);
    chk("p1_rdata", bus.p1_rdata, e_rd1);
    chk("sram_ce", bus.sram_ce, e_ce);
    chk("sram_we", bus.sram_we, e_we);
    chk("sram_addr", bus.sram_addr, e_addr);
    chk("sram_din", bus.sram_din, e_din);
    if (bus.p0_rvalid) rv0_cnt++;
    if (bus.p1_rvalid) rv1_cnt++;
    e_ce = 1'b0;
    e_we = 1'b0;
    if (rst_n && eg != 2'b00) begin
      w = eg[1] ? bus.p1_we : bus.p0_we;
      a = eg[1] ? bus.p1_addr : bus.p0_addr;
      d = eg[1] ? bus.p1_wdata : bus.p0_wdata;
      e_ce = 1'b1;
      e_we = w;
      e_addr = a;
      e_din = d;
      if (w) begin pw = 1'b1; pw_a = a; pw_d = d; end
      else pend.push_back('{eg[1], ref_mem[a], cyc + LAT + 2});
      if (&eg == 1'b0 && bus.p0_valid && bus.p1_valid) mprio = ~mprio;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int p, input logic v, input logic we, input int ad, input int dt);
    if (p == 0) begin
      bus.p0_valid = v; bus.p0_we = we; bus.p0_addr = ad[AW-1:0]; bus.p0_wdata = dt[DW-1:0];
    end else begin
      bus.p1_valid = v; bus.p1_we = we; bus.p1_addr = ad[AW-1:0]; bus.p1_wdata = dt[DW-1:0];
    end
  endtask
  int base, streak;
  initial begin
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    drv(0, 1, 1, 0, 0);
    repeat (5) tick();
    chk("rst_ce", bus.sram_ce, 0);
    chk("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
    chk("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
    rst_n = 1'b1;
    #2 chk("rel_p0_ready", bus.p0_ready, 1);
    tick();
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      drv(1, 1, 1, i, i & 255);
      tick();
    end
    base = rv1_cnt;
    streak = 0;
    for (int i = 0; i < 1024; i++) begin
      drv(1, 1, 0, i, 0);
      #2 if (bus.p1_ready) streak++;
      tick();
    end
    drv(1, 0, 0, 0, 0);
    chk("p1_ready_streak", streak, 1024);
    repeat (4) tick();
    chk("p1_burst_rvalids", rv1_cnt - base, 1024);
    drv(0, 1, 1, 37, 8'hA5);
    tick();
    drv(0, 1, 0, 37, 0);
    base = rv1_cnt;
    tick();
    drv(0, 0, 0, 0, 0);
    tick();
    chk("wr_rd_early", bus.p0_rvalid, 0);
    tick();
    chk("wr_rd_rvalid", bus.p0_rvalid, 1);
    chk("wr_rd_data", bus.p0_rdata, 8'hA5);
    tick();
    chk("wr_rd_pulse", bus.p0_rvalid, 0);
    chk("wr_rd_p1_quiet", rv1_cnt - base, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drv(0, 1, 1, 1, 8'h11);
    tick();
    drv(0, 1, 1, 2, 8'h22);
    tick();
    drv(0, 1, 0, 1, 0);
    drv(1, 1, 0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      #2 chk("rr_grant", {bus.p1_ready, bus.p0_ready}, (i % 2) != 0 ? 2 : 1);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    tick();
    tick();
    chk("rr_p0_data", bus.p0_rdata, 8'h11);
    chk("rr_p1_data", bus.p1_rdata, 8'h22);
    drv(0, 1, 0, 5, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    base = rv0_cnt;
    repeat (5) tick();
    chk("rst_drop_rvalid", rv0_cnt - base, 0);
    drv(0, 1, 0, 5, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("post_rst_rvalid", bus.p0_rvalid, 1);
    chk("post_rst_data", bus.p0_rdata, 8'h05);
    drv(0, 1, 0, 1, 0);
    drv(1, 1, 0, 2, 0);
    tick();
    drv(0, 1, 1, 9, 8'h3C);
    drv(1, 1, 0, 9, 0);
    #2 chk("conf_p1_first", {bus.p1_ready, bus.p0_ready}, 2);
    tick();
    drv(1, 0, 0, 0, 0);
    #2 chk("conf_p0_next", {bus.p1_ready, bus.p0_ready}, 1);
    tick();
    drv(0, 0, 0, 0, 0);
    tick();
    chk("conf_old_rvalid", bus.p1_rvalid, 1);
    chk("conf_old_data", bus.p1_rdata, 8'h09);
    drv(1, 1, 0, 9, 0);
    tick();
    drv(1, 0, 0, 0, 0);
    tick();
    tick();
    chk("conf_new_data", bus.p1_rdata, 8'h3C);
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drv(0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom_range(0, 255));
      drv(1, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom_range(0, 255));
      tick();
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    repeat (6) tick();
    chk("drain", pend.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_b_arbiter.md
# sram_b_arbiter

Two-port round-robin arbiter and sequencer for the 1024×8 single-port `sram_B` weight/activation buffer. It shares the SRAM between a host loader (port 0) and the NPU compute engine (port 1). Each port uses a valid/ready request handshake, and each read returns a one-cycle response pulse. It sits directly in front of `sram_B` and owns every `sram_B` pin.

## Interface
- `ADDR_W`, 10, SRAM address width (1024 words)
- `DATA_W`, 8, SRAM data width
- `RD_LAT`, 1, SRAM read latency: edges from the command-sampling edge to `dout` valid; legal values 1..3
- `clk`  in  1  single clock for all logic
- `rst_n`  in  1  reset, asynchronous and active-low
- `p0_valid`, `p1_valid`  in  1  request present
- `p0_ready`, `p1_ready`  out  1  request accepted this cycle (grant)
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  ADDR_W  word address
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data
- `p0_rvalid`, `p1_rvalid`  out  1  read data valid, one-cycle pulse
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data, held until the next response on that port
- `sram_ce`  out  1  to `sram_B.ce`
- `sram_we`  out  1  to `sram_B.we`
- `sram_addr`  out  ADDR_W  to `sram_B.addr`
- `sram_din`  out  DATA_W  to `sram_B.din`
- `sram_dout`  in  DATA_W  from `sram_B.dout`

## Operation
- A transfer occurs when `pN_valid && pN_ready`.
- `pN_ready` is combinational from the two valids and the priority pointer `prio`. The SRAM never stalls, so a lone requester is always granted.
- At most one ready is high per cycle. `pN_ready` is 0 whenever `pN_valid` is 0.
- Arbitration:
  - Both valid: grant goes to port `prio`. After the grant, `prio` flips to the other port.
  - Only one valid: that port is granted and `prio` is unchanged.
- Command stage:
  - On an accepting edge, `sram_ce`=1 and `sram_we/addr/din` are registered from the granted port.
  - On an edge with no transfer, `sram_ce`=0 and `sram_we`=0; addr/din hold.
- Read tracking: a shift pipe of depth RD_LAT+1 carries `{valid, port}` for each accepted read.
  - At the pipe tail, `sram_dout` is captured into `pN_rdata` of the tagged port.
  - `pN_rvalid` is set for exactly one cycle.
  - The other port's rdata/rvalid are unaffected.
- Writes generate no response. The write completes at the edge after acceptance.
- Ordering is strict acceptance order across both ports. A read accepted after a write to the same address returns the new data.
- Addresses are used as-is (full 10-bit range, no wrap logic). Widths are fixed by parameters with no truncation.

## Timing
- Reset values: `pN_ready` follows inputs (`prio`=0, so port 0 wins ties). `pN_rvalid`=0, `pN_rdata`=0, `sram_ce`=0, `sram_we`=0, `sram_addr`=0, `sram_din`=0, pipe empty.
- Read accepted at edge E0:
  - `sram_B` samples the command at E1.
  - rdata/rvalid update at edge E0+RD_LAT+1. Default: visible 2 cycles after acceptance.
- Throughput: one transfer per cycle sustained, any read/write mix.
- Both ports continuously valid: grants alternate 0,1,0,1… Worst-case wait is 1 cycle, so there is no starvation.
- Simultaneous events: a new acceptance and a response retiring on the same edge are independent and both take effect.
- Reset asserted mid-operation:
  - All outputs go immediately to reset values.
  - In-flight reads are dropped; no rvalid occurs after reset release.
  - SRAM contents are not cleared.

## Structure
- Shared package `npu_sram_pkg`:
  - constants `SRAM_B_ADDR_W`=10, `SRAM_B_DATA_W`=8, `SRAM_B_RD_LAT`=1
  - typedef `port_id_t` (1 bit)
  - typedef `sram_cmd_t` {we, addr, din}
- One sub-module, `rr_arb2`: two-request round-robin grant logic plus the `prio` flop.
- The command register and the response pipe live in the top.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles with `p0_valid`=1 → `sram_ce`=0, both rvalid=0, both rdata=00. After release, `p0_ready`=1 the same cycle.
- Port 0 writes 8'hA5 to 10'd37, then reads 10'd37 the next cycle → one `p0_rvalid` pulse exactly 2 cycles after read acceptance with `p0_rdata`=A5. `p1_rvalid` stays 0.
- Both ports valid for 6 cycles, reading 10'd1 (port 0) and 10'd2 (port 1), preloaded 11/22 → grants 0,1,0,1,0,1. rvalid pulses alternate with rdata 11/22.
- Port 1 alone issues back-to-back reads of 10'd0..10'd1023, preloaded with addr[7:0] → ready every cycle, 1024 consecutive rvalid pulses, data matches addr[7:0].
- Port 0 read of 10'd5 accepted, then `rst_n` pulsed low 1 cycle later → no `p0_rvalid` ever appears for that read. A fresh read after reset returns correct data.
- Same-cycle conflict: port 0 writes 10'd9=3C while port 1 reads 10'd9, `prio`=1 → port 1 reads old value first, then port 0's write lands. A following port 1 read returns 3C.
